// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main-control FSM and its ALU decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    ILLEGAL
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation and flag-write decode; only active during the execute states.
// funct here is Instr[24:20]: [4:1]=cmd, [0]=S.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       aluOp,
  input  logic [4:0] funct,
  output logic [1:0] aluControl,
  output logic [1:0] flagW
);

  logic [3:0] cmd;
  logic       arith;

  assign cmd   = funct[4:1];
  assign arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);

  always_comb begin
    aluControl = 2'b00;
    flagW      = 2'b00;
    if (aluOp) begin
      case (cmd)
        CMD_ADD:          aluControl = 2'b00;
        CMD_SUB, CMD_CMP: aluControl = 2'b01;
        CMD_AND:          aluControl = 2'b10;
        CMD_ORR:          aluControl = 2'b11;
        default:          aluControl = 2'b00;
      endcase
      // N/Z always follow S; C/V only make sense for arithmetic ops
      flagW = {funct[0], funct[0] & arith};
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle processor main control: Moore FSM plus combinational ALU/immediate decode.
// Build option MC_FSM_ILLEGAL_TRAP_EN: op=11 traps in ILLEGAL and drives the illegal port.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC+4
// DECODE   | read registers, pick instruction class
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write loaded data to register file
// MEMWRITE | write data memory
// EXECUTER | ALU op with register operand
// EXECUTEI | ALU op with immediate operand
// ALUWB    | write ALU result (suppressed for CMP)
// BRANCH   | compute branch target, redirect PC
// ILLEGAL  | trapped on undefined op until reset (trap build only)
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       regW,
  output logic       memW,
  output logic       nextPC,
  output logic [1:0] flagW,
  output logic       irWrite,
  output logic       adrSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [1:0] aluControl,
  output logic [1:0] immSrc,
  output logic [1:0] regSrc
`ifdef MC_FSM_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  state_t     state, state_next;
  logic       ir_write, next_pc, adr_src, alu_op, reg_w, mem_w, branch, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       dec_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    adr_src    = 1'b0;
    alu_op     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    trap       = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_next = DECODE;
      end
      DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_next = BRANCH;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
          default: state_next = ILLEGAL;
`else
          default: state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_b  = 2'b01;
        state_next = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_w      = 1'b1;
        state_next = FETCH;
      end
      EXECUTER: begin
        alu_op     = 1'b1;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        alu_src_b  = 2'b01;
        alu_op     = 1'b1;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_w      = (funct[4:1] != CMD_CMP);
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_next = FETCH;
      end
      ILLEGAL: begin
        trap = 1'b1;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
        state_next = ILLEGAL;
`else
        state_next = FETCH;
`endif
      end
      default: state_next = FETCH;
    endcase
  end

  // reset already forces FETCH; only its strobes need gating to stay quiet
  assign irWrite   = ir_write & rst;
  assign nextPC    = next_pc & rst;
  assign adrSrc    = adr_src;
  assign aluSrcA   = alu_src_a;
  assign aluSrcB   = alu_src_b;
  assign resultSrc = result_src;
  assign regW      = reg_w;
  assign memW      = mem_w;
  assign pcs       = ((rd == 4'hF) & reg_w) | branch;

  assign dec_en = rst & ~trap;
  assign immSrc = dec_en ? op : 2'b00;
  assign regSrc = dec_en ? {op == OP_MEM, op == OP_BR} : 2'b00;

`ifdef MC_FSM_ILLEGAL_TRAP_EN
  assign illegal = trap;
`endif

  alu_decoder u_alu_decoder (
    .aluOp      (alu_op),
    .funct      (funct[4:0]),
    .aluControl (aluControl),
    .flagW      (flagW)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: instruction table, corner sequences, random run.
`timescale 1ns/1ps
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] rd = 4'b0;
  logic       pcs, regW, memW, nextPC, irWrite, adrSrc;
  logic [1:0] flagW, aluSrcA, aluSrcB, resultSrc, aluControl, immSrc, regSrc;
  logic       ill_bit;

  always #5 clk = ~clk;

`ifdef MC_FSM_ILLEGAL_TRAP_EN
  logic illegal;
  assign ill_bit = illegal;
`else
  assign ill_bit = 1'b0;
`endif

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .rd(rd),
    .pcs(pcs), .regW(regW), .memW(memW), .nextPC(nextPC), .flagW(flagW),
    .irWrite(irWrite), .adrSrc(adrSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .resultSrc(resultSrc), .aluControl(aluControl), .immSrc(immSrc), .regSrc(regSrc)
`ifdef MC_FSM_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  typedef enum int {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                    T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_ILLEGAL} tst_t;

  typedef struct packed {
    logic       pcs, regW, memW, nextPC;
    logic [1:0] flagW;
    logic       irWrite, adrSrc;
    logic [1:0] aluSrcA, aluSrcB, resultSrc, aluControl, immSrc, regSrc;
    logic       illegal;
  } out_t;

  typedef struct {
    string      nm;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         len, regw_cyc, memw_cyc, pcs_cyc, alu_cyc;
    logic [1:0] ctrl, flagw;
  } vec_t;

  out_t act;
  assign act = '{pcs, regW, memW, nextPC, flagW, irWrite, adrSrc, aluSrcA, aluSrcB,
                 resultSrc, aluControl, immSrc, regSrc, ill_bit};

  int   checks = 0;
  int   errors = 0;
  tst_t mst = T_FETCH;

  function automatic logic [1:0] alu_ctrl_of(logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b1010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic out_t ref_out(tst_t st, logic [1:0] o, logic [5:0] f, logic [3:0] r, bit in_rst);
    out_t e;
    bit   alu, br;
    e = '0; alu = 0; br = 0;
    case (st)
      T_FETCH:    begin e.irWrite = !in_rst; e.nextPC = !in_rst;
                        e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.resultSrc = 2'b10; end
      T_DECODE:   begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.resultSrc = 2'b10; end
      T_MEMADR:   e.aluSrcB = 2'b01;
      T_MEMREAD:  e.adrSrc = 1'b1;
      T_MEMWB:    begin e.resultSrc = 2'b01; e.regW = 1'b1; end
      T_MEMWRITE: begin e.adrSrc = 1'b1; e.memW = 1'b1; end
      T_EXECR:    alu = 1;
      T_EXECI:    begin alu = 1; e.aluSrcB = 2'b01; end
      T_ALUWB:    e.regW = (f[4:1] != 4'b1010);
      T_BRANCH:   begin e.aluSrcB = 2'b01; e.resultSrc = 2'b10; br = 1; end
      T_ILLEGAL:  e.illegal = 1'b1;
      default:    e = '0;
    endcase
    if (alu) begin
      e.aluControl = alu_ctrl_of(f[4:1]);
      e.flagW = {f[0], f[0] && (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010)};
    end
    e.pcs = (r == 4'hF && e.regW) || br;
    if (!in_rst && st != T_ILLEGAL) begin
      e.immSrc = o;
      e.regSrc = {o == 2'b01, o == 2'b10};
    end
    return e;
  endfunction

  function automatic tst_t next_st(tst_t st, logic [1:0] o, logic [5:0] f);
    case (st)
      T_FETCH:  return T_DECODE;
      T_DECODE: begin
        if (o == 2'b01) return T_MEMADR;
        if (o == 2'b00) return f[5] ? T_EXECI : T_EXECR;
        if (o == 2'b10) return T_BRANCH;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
        return T_ILLEGAL;
`else
        return T_FETCH;
`endif
      end
      T_MEMADR:         return f[0] ? T_MEMREAD : T_MEMWRITE;
      T_MEMREAD:        return T_MEMWB;
      T_EXECR, T_EXECI: return T_ALUWB;
      T_ILLEGAL:        return T_ILLEGAL;
      default:          return T_FETCH;
    endcase
  endfunction

  task automatic chk_out(string nm);
    out_t e;
    e = ref_out(mst, op, funct, rd, !rst);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: state_model=%s got %b expected %b", nm, mst.name(), act, e);
    end
  endtask

  task automatic chk_val(string nm, logic [1:0] got, logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    mst = rst ? next_st(mst, op, funct) : T_FETCH;
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"ldr",    2'b01, 6'b011001, 4'd3,  5, 5, 0, 0, 0, 2'b00, 2'b00};
    vecs[1]  = '{"str",    2'b01, 6'b011000, 4'd3,  4, 0, 4, 0, 0, 2'b00, 2'b00};
    vecs[2]  = '{"adds",   2'b00, 6'b001001, 4'd2,  4, 4, 0, 0, 3, 2'b00, 2'b11};
    vecs[3]  = '{"subs",   2'b00, 6'b000101, 4'd2,  4, 4, 0, 0, 3, 2'b01, 2'b11};
    vecs[4]  = '{"cmp_i",  2'b00, 6'b110101, 4'd0,  4, 0, 0, 0, 3, 2'b01, 2'b11};
    vecs[5]  = '{"b",      2'b10, 6'b000000, 4'd0,  3, 0, 0, 3, 0, 2'b00, 2'b00};
    vecs[6]  = '{"add_pc", 2'b00, 6'b001000, 4'd15, 4, 4, 0, 4, 3, 2'b00, 2'b00};
    vecs[7]  = '{"orr",    2'b00, 6'b011000, 4'd1,  4, 4, 0, 0, 3, 2'b11, 2'b00};
    vecs[8]  = '{"ands_i", 2'b00, 6'b100001, 4'd4,  4, 4, 0, 0, 3, 2'b10, 2'b10};
    vecs[9]  = '{"ldr_pc", 2'b01, 6'b111001, 4'd15, 5, 5, 0, 5, 0, 2'b00, 2'b00};
    vecs[10] = '{"str_pc", 2'b01, 6'b010000, 4'd15, 4, 0, 4, 0, 0, 2'b00, 2'b00};
    vecs[11] = '{"eors",   2'b00, 6'b000011, 4'd5,  4, 4, 0, 0, 3, 2'b00, 2'b10};

    // reset: held across edges, FETCH outputs with strobes gated
    #1 rst = 1'b0; mst = T_FETCH;
    #2 chk_out("reset_init");
    step(); chk_out("reset_hold1");
    step(); chk_out("reset_hold2");
    rst = 1'b1;

    foreach (vecs[i]) begin
      op = vecs[i].op; funct = vecs[i].funct; rd = vecs[i].rd;
      for (int c = 1; c <= vecs[i].len; c++) begin
        @(negedge clk);
        chk_out({vecs[i].nm, "_cyc"});
        chk_val({vecs[i].nm, "_irwrite"}, {1'b0, irWrite}, {1'b0, c == 1});
        chk_val({vecs[i].nm, "_regw"}, {1'b0, regW}, {1'b0, c == vecs[i].regw_cyc});
        chk_val({vecs[i].nm, "_memw"}, {1'b0, memW}, {1'b0, c == vecs[i].memw_cyc});
        chk_val({vecs[i].nm, "_pcs"}, {1'b0, pcs}, {1'b0, c == vecs[i].pcs_cyc});
        if (c == vecs[i].alu_cyc) begin
          chk_val({vecs[i].nm, "_aluctrl"}, aluControl, vecs[i].ctrl);
          chk_val({vecs[i].nm, "_flagw"}, flagW, vecs[i].flagw);
        end
        step();
      end
    end
    @(negedge clk);
    chk_val("table_end_fetch", {1'b0, irWrite}, 2'b01);

    // async reset in the middle of a store
    op = 2'b01; funct = 6'b011000; rd = 4'd1;
    step(); step(); step();
    chk_val("mw_before_rst", {1'b0, memW}, 2'b01);
    rst = 1'b0; mst = T_FETCH;
    #1 chk_val("mw_async_drop", {1'b0, memW}, 2'b00);
    chk_out("mw_rst_outputs");
    step(); chk_out("mw_rst_held");
    rst = 1'b1;
    @(negedge clk); chk_out("post_rst_fetch");
    step(); chk_out("post_rst_leave_fetch");
    for (int k = 0; k < 8 && mst != T_FETCH; k++) step();

    // undefined op=11
    op = 2'b11; funct = 6'b000000; rd = 4'd0;
    @(negedge clk); chk_out("op11_fetch");
    step(); chk_out("op11_decode");
    step(); chk_out("op11_after");
`ifdef MC_FSM_ILLEGAL_TRAP_EN
    chk_val("op11_illegal", {1'b0, ill_bit}, 2'b01);
    op = 2'b00; funct = 6'b001000;
    step(); step(); step();
    chk_val("illegal_held", {1'b0, ill_bit}, 2'b01);
    chk_out("illegal_held_outputs");
    rst = 1'b0; mst = T_FETCH;
    #1 chk_val("illegal_cleared", {1'b0, ill_bit}, 2'b00);
    chk_out("illegal_rst_outputs");
    #1 rst = 1'b1;
`else
    chk_val("op11_back_fetch", {1'b0, irWrite}, 2'b01);
`endif
    for (int k = 0; k < 8 && mst != T_FETCH; k++) step();

    // random inputs every cycle, with occasional async reset pulses
    for (int n = 0; n < 500; n++) begin
      op = 2'($urandom);
      funct = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b0; mst = T_FETCH;
        #1 chk_out("rand_rst");
        #1 rst = 1'b1;
      end
      @(negedge clk);
      chk_out("rand");
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
